// File: rtl/fetch_pkg.sv
// Shared widths, RAS geometry and the next-PC source encoding for fetch stage 1.
package fetch_pkg;

  localparam int SIZE_PC       = 32;
  localparam int RAS_DEPTH     = 16;
  localparam int RAS_DEPTH_LOG = 4;
  localparam int FETCH_BYTES   = 32;
  localparam int INST_BYTES    = 8;

  typedef logic [SIZE_PC-1:0]       pc_t;
  typedef logic [RAS_DEPTH_LOG-1:0] rasPtr_t;
  typedef logic [RAS_DEPTH_LOG:0]   rasCount_t;

  typedef enum logic [2:0] {
    SRC_COMMIT,
    SRC_EX,
    SRC_HOLD,
    SRC_ID,
    SRC_BTB,
    SRC_SEQ
  } pcSrc_e;

  function automatic pc_t returnAddr(input pc_t callPc);
    return callPc + pc_t'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch1_pc_ras_if.sv
// FS2 <-> FS1 redirect channel: FS2 drives redirect/call/return, FS1 returns the RAS top.
interface fetch1_pc_ras_if;
  import fetch_pkg::*;

  logic flagRecoverID;
  pc_t  targetAddrID;
  logic flagRtrID;
  logic flagCallID;
  pc_t  callPCID;
  pc_t  addrRAS_CP;

  modport master (
    output flagRecoverID, targetAddrID, flagRtrID, flagCallID, callPCID,
    input  addrRAS_CP
  );

  modport slave (
    input  flagRecoverID, targetAddrID, flagRtrID, flagCallID, callPCID,
    output addrRAS_CP
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return address stack with saturating count.
// RAS_CHECKPOINT_EN adds a committed pointer/count that restore copies back.
module ras_stack
  import fetch_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  pc_t       pushAddr,
  input  logic      restore,
  input  logic      commitCall,
  input  logic      commitRtr,
  output pc_t       top,
  output rasCount_t count
);

  localparam rasCount_t FULL = rasCount_t'(RAS_DEPTH);

  pc_t     mem [RAS_DEPTH];
  rasPtr_t tos;
  rasPtr_t tosInc;
  rasPtr_t tosDec;

  assign tosInc = tos + 1'b1;
  assign tosDec = tos - 1'b1;
  assign top    = mem[tos];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tosInc] <= pushAddr;
    end
  end

`ifdef RAS_CHECKPOINT_EN
  rasPtr_t   commitTos;
  rasCount_t commitCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      commitTos   <= '0;
      commitCount <= '0;
    end else if (commitCall) begin
      commitTos <= commitTos + 1'b1;
      if (commitCount != FULL) commitCount <= commitCount + 1'b1;
    end else if (commitRtr && commitCount != '0) begin
      commitTos   <= commitTos - 1'b1;
      commitCount <= commitCount - 1'b1;
    end
  end
`else
  logic unusedCheckpoint;
  assign unusedCheckpoint = restore ^ commitCall ^ commitRtr;
`endif

  // Push wins over a simultaneous pop; a pop on an empty stack is a no-op.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos   <= '0;
      count <= '0;
`ifdef RAS_CHECKPOINT_EN
    end else if (restore) begin
      tos   <= commitTos;
      count <= commitCount;
`endif
    end else if (push) begin
      tos <= tosInc;
      if (count != FULL) count <= count + 1'b1;
    end else if (pop && count != '0) begin
      tos   <= tosDec;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && pop));
    end
  end

endmodule

// File: rtl/fetch1_pc_ras.sv
// Fetch stage 1: prioritised next-PC selection, PC register and RAS wrapper.
// Optional macro RAS_CHECKPOINT_EN enables committed-state RAS recovery.
module fetch1_pc_ras
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            ctiQueueFull_i,
  input  logic            recoverFlag_i,
  input  pc_t             recoverPC_i,
  input  logic            flagRecoverEX_i,
  input  pc_t             targetAddrEX_i,
  input  logic            btbTaken_i,
  input  pc_t             btbTarget_i,
  input  logic            btbRtr_i,
  input  logic            commitCall_i,
  input  logic            commitRtr_i,
  fetch1_pc_ras_if.slave  fs2,
  output pc_t             pc_o,
  output logic            fs1Ready_o,
  output rasCount_t       rasCount_o
);

  logic   started;
  logic   adv;
  logic   rasUpdate;
  pcSrc_e pcSrc;
  pc_t    nextPc;
  pc_t    rasTop;

  assign adv        = ~stall_i & ~ctiQueueFull_i;
  assign fs1Ready_o = started & adv;
  assign rasUpdate  = adv & fs2.flagRecoverID & ~recoverFlag_i & ~flagRecoverEX_i;
  assign fs2.addrRAS_CP = rasTop;

  always_comb begin
    pcSrc = SRC_SEQ;
    if (recoverFlag_i)        pcSrc = SRC_COMMIT;
    else if (flagRecoverEX_i) pcSrc = SRC_EX;
    else if (!adv)            pcSrc = SRC_HOLD;
    else if (fs2.flagRecoverID) pcSrc = SRC_ID;
    else if (btbTaken_i)      pcSrc = SRC_BTB;
  end

  // Returns take the RAS top as read before this cycle's pop.
  always_comb begin
    nextPc = pc_o + pc_t'(FETCH_BYTES);
    case (pcSrc)
      SRC_COMMIT: nextPc = recoverPC_i;
      SRC_EX:     nextPc = targetAddrEX_i;
      SRC_HOLD:   nextPc = pc_o;
      SRC_ID:     nextPc = fs2.flagRtrID ? rasTop : fs2.targetAddrID;
      SRC_BTB:    nextPc = btbRtr_i ? rasTop : btbTarget_i;
      default:    nextPc = pc_o + pc_t'(FETCH_BYTES);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_o    <= RESET_PC;
      started <= 1'b0;
    end else begin
      pc_o    <= nextPc;
      started <= 1'b1;
    end
  end

  ras_stack uRas (
    .clk        (clk),
    .reset      (reset),
    .push       (rasUpdate & fs2.flagCallID),
    .pop        (rasUpdate & fs2.flagRtrID),
    .pushAddr   (returnAddr(fs2.callPCID)),
    .restore    (recoverFlag_i),
    .commitCall (commitCall_i),
    .commitRtr  (commitRtr_i),
    .top        (rasTop),
    .count      (rasCount_o)
  );

endmodule

// File: tb/tb_fetch1_pc_ras.sv
// Directed plus randomized bench for fetch1_pc_ras against a queue-based RAS model.
module tb_fetch1_pc_ras;
  import fetch_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      stall, ctiFull, recoverFlag, flagEX, btbTaken, btbRtr, commitCall, commitRtr;
  pc_t       recoverPC, targetEX, btbTarget;
  pc_t       pcOut;
  logic      fs1Ready;
  rasCount_t rasCount;

  fetch1_pc_ras_if fs2If();

  fetch1_pc_ras dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall),
    .ctiQueueFull_i  (ctiFull),
    .recoverFlag_i   (recoverFlag),
    .recoverPC_i     (recoverPC),
    .flagRecoverEX_i (flagEX),
    .targetAddrEX_i  (targetEX),
    .btbTaken_i      (btbTaken),
    .btbTarget_i     (btbTarget),
    .btbRtr_i        (btbRtr),
    .commitCall_i    (commitCall),
    .commitRtr_i     (commitRtr),
    .fs2             (fs2If),
    .pc_o            (pcOut),
    .fs1Ready_o      (fs1Ready),
    .rasCount_o      (rasCount)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  pc_t mPc;
  bit  mStarted;
  pc_t mStack[$];
  int  mCommit;
  bit  mSkipPc;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idleInputs();
    stall = 0; ctiFull = 0; recoverFlag = 0; flagEX = 0; btbTaken = 0; btbRtr = 0;
    commitCall = 0; commitRtr = 0; recoverPC = '0; targetEX = '0; btbTarget = '0;
    fs2If.flagRecoverID = 0; fs2If.flagRtrID = 0; fs2If.flagCallID = 0;
    fs2If.targetAddrID = '0; fs2If.callPCID = '0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pc", pcOut, 64'h0);
    checkOutput("reset count", rasCount, 64'h0);
    checkOutput("reset ready", fs1Ready, 64'h0);
    reset = 0;
    mPc = '0; mStarted = 0; mStack.delete(); mCommit = 0;
  endtask

  // One cycle: model computes expectations from the current inputs, then the edge is checked.
  task automatic applyStimulus(input string tag);
    bit  adv, upd;
    pc_t expPc;
    #1;
    adv = !stall && !ctiFull;
    checkOutput({tag, " ready"}, fs1Ready, 64'(mStarted && adv));
    mSkipPc = 0;
    expPc = mPc + 32'd32;
    if (recoverFlag) expPc = recoverPC;
    else if (flagEX) expPc = targetEX;
    else if (!adv) expPc = mPc;
    else if (fs2If.flagRecoverID) begin
      if (!fs2If.flagRtrID) expPc = fs2If.targetAddrID;
      else if (mStack.size() > 0) expPc = mStack[$];
      else mSkipPc = 1;
    end else if (btbTaken) begin
      if (!btbRtr) expPc = btbTarget;
      else if (mStack.size() > 0) expPc = mStack[$];
      else mSkipPc = 1;
    end
    upd = adv && fs2If.flagRecoverID && !recoverFlag && !flagEX;
    if (upd && fs2If.flagCallID) begin
      if (mStack.size() == RAS_DEPTH) void'(mStack.pop_front());
      mStack.push_back(fs2If.callPCID + 32'd8);
    end else if (upd && fs2If.flagRtrID && mStack.size() > 0) begin
      void'(mStack.pop_back());
    end
`ifdef RAS_CHECKPOINT_EN
    if (recoverFlag) while (mStack.size() > mCommit) void'(mStack.pop_back());
`endif
    if (commitCall) mCommit = (mCommit < RAS_DEPTH) ? mCommit + 1 : mCommit;
    else if (commitRtr && mCommit > 0) mCommit--;
    mPc = expPc;
    mStarted = 1;
    @(posedge clk);
    #1;
    if (!mSkipPc) checkOutput({tag, " pc"}, pcOut, 64'(mPc));
    else mPc = pcOut;
    checkOutput({tag, " count"}, rasCount, 64'(mStack.size()));
    if (mStack.size() > 0) checkOutput({tag, " top"}, fs2If.addrRAS_CP, 64'(mStack[$]));
  endtask

  task automatic idCall(input pc_t callPc, input pc_t target);
    idleInputs();
    fs2If.flagRecoverID = 1; fs2If.flagCallID = 1;
    fs2If.callPCID = callPc; fs2If.targetAddrID = target;
  endtask

  task automatic idReturn();
    idleInputs();
    fs2If.flagRecoverID = 1; fs2If.flagRtrID = 1;
  endtask

  initial begin
    doReset();

    // Sequential fetch out of reset.
    repeat (3) applyStimulus("seq");
    checkOutput("seq pc3", pcOut, 64'h60);

    // Single call / return pair.
    idCall(32'h1000, 32'h2000);
    applyStimulus("call");
    checkOutput("call top", fs2If.addrRAS_CP, 64'h1008);
    idReturn();
    applyStimulus("ret");
    checkOutput("ret pc", pcOut, 64'h1008);

    // Overflow, drain and pop on empty.
    doReset();
    for (int k = 1; k <= 17; k++) begin
      idCall(pc_t'(32'h100 * k), 32'h3000);
      applyStimulus("push");
    end
    checkOutput("full count", rasCount, 64'd16);
    checkOutput("full top", fs2If.addrRAS_CP, 64'h1108);
    for (int k = 0; k < 16; k++) begin
      idReturn();
      applyStimulus("pop");
    end
    checkOutput("last pop pc", pcOut, 64'h208);
    idReturn();
    applyStimulus("empty pop");
    checkOutput("empty pop pc", pcOut, 64'h1108);
    checkOutput("empty pop count", rasCount, 64'd0);
    checkOutput("empty pop top", fs2If.addrRAS_CP, 64'h1108);

    // EX recovery squashes a same-cycle ID call.
    idCall(32'h5000, 32'h6000);
    flagEX = 1; targetEX = 32'h4000;
    applyStimulus("ex squash");
    checkOutput("ex squash pc", pcOut, 64'h4000);
    checkOutput("ex squash count", rasCount, 64'd0);

    // Stall holds the PC and blocks the redirect until released.
    idCall(32'h7000, 32'h7800);
    stall = 1;
    applyStimulus("stalled");
    checkOutput("stalled pc", pcOut, 64'h4000);
    stall = 0;
    applyStimulus("unstalled");
    checkOutput("unstalled pc", pcOut, 64'h7800);

    // Checkpoint restore on commit recovery.
    doReset();
    idCall(32'h100, 32'h1000); applyStimulus("cp call1");
    idCall(32'h200, 32'h2000); applyStimulus("cp call2");
    idleInputs(); commitCall = 1; applyStimulus("cp commit1");
    idleInputs(); commitCall = 1; applyStimulus("cp commit2");
    idCall(32'h300, 32'h3000); applyStimulus("cp spec");
    idleInputs(); recoverFlag = 1; recoverPC = 32'h8000;
    applyStimulus("cp recover");
`ifdef RAS_CHECKPOINT_EN
    checkOutput("cp count", rasCount, 64'd2);
`else
    checkOutput("cp count", rasCount, 64'd3);
`endif

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      idleInputs();
      stall       = ($urandom_range(0, 9) == 0);
      ctiFull     = ($urandom_range(0, 9) == 0);
      recoverFlag = ($urandom_range(0, 29) == 0);
      recoverPC   = {$urandom_range(0, 32'hFFFF), 5'b0};
      flagEX      = ($urandom_range(0, 19) == 0);
      targetEX    = {$urandom_range(0, 32'hFFFF), 5'b0};
      btbTaken    = ($urandom_range(0, 3) == 0);
      btbTarget   = {$urandom_range(0, 32'hFFFF), 5'b0};
      btbRtr      = (mStack.size() > 0) && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) begin
        fs2If.flagRecoverID = 1;
        fs2If.targetAddrID  = {$urandom_range(0, 32'hFFFF), 5'b0};
        fs2If.callPCID      = {$urandom_range(0, 32'hFFFFF), 3'b0};
        if ($urandom_range(0, 1) == 0) fs2If.flagCallID = 1;
        else if (mStack.size() > 0 && $urandom_range(0, 1) == 0) fs2If.flagRtrID = 1;
      end
      applyStimulus("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
